l1_cmd_scheduler: RTL and testbench

//  Front-end sequencer for the split L1 (data cache + instruction cache).

---
 rtl/l1_cmd_scheduler.sv | 126 ++++++++++++
 tb/tb_l1_cmd_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cmd_scheduler.sv
// Buffers trace commands and dispatches one per cycle to the data/instruction cache ports.
// Latency: 1 cycle from accept to registered dispatch; cmd_ready drops only when the FIFO is full.
module l1_cmd_scheduler #(
  parameter int         ADDR_W   = 32,
  parameter int         DEPTH    = 8,
  parameter int         CLR_GAP  = 2,
  parameter logic [3:0] NOP_CODE = 4'hF,
  parameter int         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_n,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic [3:0]        dc_n,
  output logic [ADDR_W-1:0] dc_address,
  output logic [3:0]        ic_n,
  output logic [ADDR_W-1:0] ic_address,
  output logic              busy,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  dropped_cnt
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [3:0]     GAP_INIT = 4'(CLR_GAP);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [3:0]        fifo_n    [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  state_t            state;
  logic [3:0]        gap;

  logic              push, pop, empty, full;
  logic [3:0]        head_n;
  logic [ADDR_W-1:0] head_addr;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign head_n    = fifo_n[rd_ptr];
  assign head_addr = fifo_addr[rd_ptr];
  assign busy      = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_n[wr_ptr]    <= cmd_n;
      fifo_addr[wr_ptr] <= cmd_addr;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gap         <= '0;
      dc_n        <= NOP_CODE;
      ic_n        <= NOP_CODE;
      dc_address  <= '0;
      ic_address  <= '0;
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      dc_n <= NOP_CODE;
      ic_n <= NOP_CODE;
      case (state)
        IDLE: begin
          if (pop) begin
            case (head_n)
              4'd0, 4'd1, 4'd3, 4'd4: begin
                dc_n       <= head_n;
                dc_address <= head_addr;
                if (issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
              end
              4'd2: begin
                ic_n       <= head_n;
                ic_address <= head_addr;
                if (issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
              end
              4'd8, 4'd9: begin
                dc_n       <= head_n;
                dc_address <= head_addr;
                ic_n       <= head_n;
                ic_address <= head_addr;
                state      <= HOLD;
                gap        <= GAP_INIT;
                if (issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
              end
              default: begin
                if (dropped_cnt != '1) dropped_cnt <= dropped_cnt + 1'b1;
              end
            endcase
          end
        end
        HOLD: begin
          // The cycle that sees gap==1 is the last forced NOP.
          if (gap == 4'd1) state <= IDLE;
          gap <= gap - 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_cmd_scheduler.sv
// Directed bench for l1_cmd_scheduler: queue-based reference model checked every cycle plus literal expectations.
module tb_l1_cmd_scheduler;
  localparam int         ADDR_W  = 32;
  localparam int         DEPTH   = 8;
  localparam int         CLR_GAP = 2;
  localparam int         CNT_W   = 16;
  localparam logic [3:0] NOP     = 4'hF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [3:0]        cmd_n = 4'd0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic              cmd_ready, busy;
  logic [3:0]        dc_n, ic_n;
  logic [ADDR_W-1:0] dc_address, ic_address;
  logic [CNT_W-1:0]  issued_cnt, dropped_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l1_cmd_scheduler #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLR_GAP(CLR_GAP), .NOP_CODE(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n(cmd_n), .cmd_addr(cmd_addr),
    .dc_n(dc_n), .dc_address(dc_address), .ic_n(ic_n), .ic_address(ic_address),
    .busy(busy), .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted commands and a count of forced NOP cycles still owed.
  logic [3:0]        q_n [$];
  logic [ADDR_W-1:0] q_a [$];
  int                m_hold, m_issued, m_dropped;
  logic [3:0]        m_dc_n, m_ic_n, m_pn;
  logic [ADDR_W-1:0] m_dc_a, m_ic_a, m_pa;
  bit                m_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_n.delete();
      q_a.delete();
      m_hold = 0; m_issued = 0; m_dropped = 0;
      m_dc_n = NOP; m_ic_n = NOP; m_dc_a = '0; m_ic_a = '0;
    end else begin
      m_push = cmd_valid && (q_n.size() < DEPTH);
      m_dc_n = NOP;
      m_ic_n = NOP;
      if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end else if (q_n.size() > 0) begin
        m_pn = q_n.pop_front();
        m_pa = q_a.pop_front();
        if (m_pn == 4'd2) begin
          m_ic_n = m_pn; m_ic_a = m_pa; m_issued++;
        end else if (m_pn == 4'd0 || m_pn == 4'd1 || m_pn == 4'd3 || m_pn == 4'd4) begin
          m_dc_n = m_pn; m_dc_a = m_pa; m_issued++;
        end else if (m_pn == 4'd8 || m_pn == 4'd9) begin
          m_dc_n = m_pn; m_dc_a = m_pa; m_ic_n = m_pn; m_ic_a = m_pa;
          m_issued++;
          m_hold = CLR_GAP;
        end else begin
          m_dropped++;
        end
      end
      if (m_push) begin
        q_n.push_back(cmd_n);
        q_a.push_back(cmd_addr);
      end
    end
  end

  always @(negedge clk) begin
    chk("dc_n", dc_n, m_dc_n);
    chk("ic_n", ic_n, m_ic_n);
    chk("dc_address", dc_address, m_dc_a);
    chk("ic_address", ic_address, m_ic_a);
    chk("cmd_ready", cmd_ready, q_n.size() < DEPTH);
    chk("busy", busy, (q_n.size() != 0) || (m_hold > 0));
    chk("issued_cnt", issued_cnt, m_issued);
    chk("dropped_cnt", dropped_cnt, m_dropped);
  end

  task automatic do_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] n, input logic [ADDR_W-1:0] a);
    cmd_valid = 1'b1;
    cmd_n     = n;
    cmd_addr  = a;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("drain_timeout", busy, 1'b0);
  endtask

  int accepted, cycles, first_stall, ghost;
  bit acc;

  initial begin
    do_reset();
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dc_n", dc_n, NOP);

    // single data-cache command, one-cycle latency
    drive(4'd0, 32'h0000_1040);
    cmd_valid = 1'b0;
    chk("t1_dc_before", dc_n, NOP);
    @(negedge clk);
    chk("t1_dc_n", dc_n, 4'd0);
    chk("t1_dc_addr", dc_address, 32'h0000_1040);
    chk("t1_ic_n", ic_n, NOP);
    chk("t1_issued", issued_cnt, 1);
    @(negedge clk);
    chk("t1_dc_n_after", dc_n, NOP);
    chk("t1_dc_addr_hold", dc_address, 32'h0000_1040);

    // back-to-back instruction then data
    do_reset();
    drive(4'd2, 32'h400);
    drive(4'd1, 32'h800);
    cmd_valid = 1'b0;
    chk("t2_ic_n", ic_n, 4'd2);
    chk("t2_ic_addr", ic_address, 32'h400);
    chk("t2_dc_idle", dc_n, NOP);
    @(negedge clk);
    chk("t2_dc_n", dc_n, 4'd1);
    chk("t2_dc_addr", dc_address, 32'h800);
    chk("t2_ic_idle", ic_n, NOP);

    // broadcast followed by the clear gap
    do_reset();
    drive(4'd8, 32'h100);
    drive(4'd0, 32'h40);
    cmd_valid = 1'b0;
    chk("t3_dc_8", dc_n, 4'd8);
    chk("t3_ic_8", ic_n, 4'd8);
    chk("t3_ic_addr", ic_address, 32'h100);
    @(negedge clk);
    chk("t3_gap1", {dc_n, ic_n}, {NOP, NOP});
    @(negedge clk);
    chk("t3_gap2", {dc_n, ic_n}, {NOP, NOP});
    @(negedge clk);
    chk("t3_dc_0", dc_n, 4'd0);
    chk("t3_dc_addr", dc_address, 32'h40);
    chk("t3_issued", issued_cnt, 2);

    // sustained broadcasts fill the FIFO while HOLD throttles the pops
    do_reset();
    accepted = 0; cycles = 0; first_stall = -1;
    cmd_valid = 1'b1;
    while (accepted < 14 && cycles < 200) begin
      cmd_n    = accepted[0] ? 4'd8 : 4'd9;
      cmd_addr = 32'h1000 + 32'(accepted * 4);
      acc = cmd_ready;
      if (!acc && first_stall < 0) first_stall = accepted;
      @(negedge clk);
      if (acc) accepted++;
      cycles++;
    end
    cmd_valid = 1'b0;
    chk("t4_accepted", accepted, 14);
    chk("t4_first_stall", first_stall, 12);
    wait_idle();
    chk("t4_issued", issued_cnt, 14);
    chk("t4_dropped", dropped_cnt, 0);

    // illegal codes are consumed but never dispatched
    do_reset();
    drive(4'd5, 32'h11);
    drive(4'd7, 32'h22);
    drive(4'd3, 32'h80);
    cmd_valid = 1'b0;
    chk("t5_dropped", dropped_cnt, 2);
    chk("t5_no_dc", dc_n, NOP);
    chk("t5_dc_addr_hold", dc_address, 32'h0);
    @(negedge clk);
    chk("t5_dc_3", dc_n, 4'd3);
    chk("t5_dc_addr", dc_address, 32'h80);
    chk("t5_issued", issued_cnt, 1);
    @(negedge clk);
    chk("t5_dc_after", dc_n, NOP);

    // reset while queued and mid-HOLD
    do_reset();
    drive(4'd9, 32'h10);
    drive(4'd9, 32'h20);
    drive(4'd1, 32'h30);
    drive(4'd1, 32'h34);
    drive(4'd1, 32'h38);
    drive(4'd1, 32'h3C);
    cmd_valid = 1'b0;
    chk("t6_busy_pre", busy, 1'b1);
    chk("t6_issued_pre", issued_cnt, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_dc_nop", dc_n, NOP);
    chk("t6_ic_nop", ic_n, NOP);
    chk("t6_busy", busy, 1'b0);
    chk("t6_issued", issued_cnt, 0);
    chk("t6_dropped", dropped_cnt, 0);
    chk("t6_ready", cmd_ready, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    ghost = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dc_n != NOP || ic_n != NOP) ghost++;
    end
    chk("t6_no_ghost", ghost, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
